pll_clken_gen: RTL and testbench

Parametrised clock-enable generator that sits directly behind the system PLL and derives NUM_CH independent fractional-rate enable strobes from the single PLL output clock, using phase accumulators instead of extra PLL outputs. It synchronises and filters the PLL `locked` signal, holds all strobes off until lock has been stable for LOCK_FILTER cycles, and drops them immediately on lock loss. Downstream cores (CPU, video, audio) run on `refclk` and are gated by `clken`.

---
 rtl/pll_pkg.sv | 14 +
 rtl/pll_clken_gen_if.sv | 25 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_clken_gen.sv | 105 ++++++++++
 tb/tb_pll_clken_gen.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL clock-enable generator.
package pll_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RUN       = 2'd2
  } pll_state_t;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_ACC_W       = 24;
  localparam int DEF_LOCK_FILTER = 1024;

endpackage

// File: rtl/pll_clken_gen_if.sv
// Control/status bundle between the clock-enable generator and its user.
interface pll_clken_gen_if #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 24
);

  logic [NUM_CH*ACC_W-1:0] inc;
  logic [NUM_CH-1:0]       ch_en;
  logic                    phase_align;
  logic                    lost_clr;
  logic [NUM_CH-1:0]       clken;
  logic                    ready;
  logic                    lock_lost;

  modport master (
    output inc, ch_en, phase_align, lost_clr,
    input  clken, ready, lock_lost
  );

  modport slave (
    input  inc, ch_en, phase_align, lost_clr,
    output clken, ready, lock_lost
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_clken_gen.sv
// Lock-qualified fractional-rate clock-enable strobes from one PLL clock.
module pll_clken_gen
  import pll_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
  input  logic refclk,
  input  logic rst,
  input  logic pll_locked,
  pll_clken_gen_if.slave bus
);

  localparam int CNT_W =
    (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(LOCK_FILTER - 1);

  logic             locked_s;
  pll_state_t       state;
  pll_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             drop;
  logic             hold;
  logic             lost_q;

  logic [ACC_W-1:0] acc   [NUM_CH];
  logic             carry [NUM_CH];

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) state <= WAIT_LOCK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_LOCK: if (locked_s) state_nxt = FILTER;
      FILTER: begin
        if (!locked_s)            state_nxt = WAIT_LOCK;
        else if (cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN:     if (!locked_s) state_nxt = WAIT_LOCK;
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    run  = (state == RUN);
    drop = run && !locked_s;
  end

  // Counter only advances while staying in FILTER.
  always_ff @(posedge refclk) begin
    if (rst || state != FILTER || state_nxt != FILTER)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst)               lost_q <= 1'b0;
    else if (drop)         lost_q <= 1'b1;
    else if (bus.lost_clr) lost_q <= 1'b0;
  end

  // Leaving RUN this edge must already zero the strobes.
  assign hold = !run || drop || bus.phase_align;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W:0] sum;

    assign sum = {1'b0, acc[i]}
               + {1'b0, bus.inc[i*ACC_W +: ACC_W]};

    always_ff @(posedge refclk) begin
      if (rst || hold || !bus.ch_en[i]) begin
        acc[i]   <= '0;
        carry[i] <= 1'b0;
      end else begin
        acc[i]   <= sum[ACC_W-1:0];
        carry[i] <= sum[ACC_W];
      end
    end
  end

  always_comb begin
    bus.clken = '0;
    for (int i = 0; i < NUM_CH; i++)
      bus.clken[i] = carry[i];
  end

  assign bus.ready     = run;
  assign bus.lock_lost = lost_q;

endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed bench for pll_clken_gen: lock filter, rates, align, loss.
module tb_pll_clken_gen;

  localparam int NCH = 2;
  localparam int AW  = 24;
  localparam int LF  = 4;

  logic refclk     = 1'b0;
  logic rst        = 1'b1;
  logic pll_locked = 1'b0;

  int errs   = 0;
  int checks = 0;

  pll_clken_gen_if #(.NUM_CH(NCH), .ACC_W(AW)) bus ();

  pll_clken_gen #(
    .NUM_CH      (NCH),
    .ACC_W       (AW),
    .LOCK_FILTER (LF)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .bus        (bus)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] st();
    return {bus.ready, bus.lock_lost, bus.clken};
  endfunction

  initial begin
    int n0, n1, bad, last, first;
    logic [1:0] e2;

    bus.inc         = {24'h100000, 24'h400000};
    bus.ch_en       = 2'b11;
    bus.phase_align = 1'b0;
    bus.lost_clr    = 1'b0;

    repeat (2) @(negedge refclk);
    rst = 1'b0;
    chk("reset", 32'(st()), 32'h0);

    // Glitch: locked sampled high at edges 1-3, low at 4, high after.
    for (int e = 1; e <= 11; e++) begin
      pll_locked = (e != 4);
      @(negedge refclk);
      chk($sformatf("glitch_e%0d", e), 32'(st()),
          (e >= 11) ? 32'h8 : 32'h0);
    end

    // Integer rates, RUN cycle 0 is now.
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge refclk);
      e2[0] = (c > 0) && (c % 4 == 0);
      e2[1] = (c > 0) && (c % 16 == 0);
      chk($sformatf("int_c%0d", c), 32'(bus.clken), 32'(e2));
    end

    // Align at end of cycle 39; drop ch1 just before its cycle-56 strobe.
    bus.phase_align = 1'b1;
    for (int c = 40; c <= 60; c++) begin
      @(negedge refclk);
      bus.phase_align = 1'b0;
      e2[0] = (c > 40) && ((c - 40) % 4 == 0);
      e2[1] = 1'b0;
      chk($sformatf("align_c%0d", c), 32'(bus.clken), 32'(e2));
      if (c == 55) bus.ch_en = 2'b01;
    end

    // Fractional ch0, zero-rate ch1.
    bus.inc         = {24'h000000, 24'h555555};
    bus.ch_en       = 2'b11;
    bus.phase_align = 1'b1;
    n0 = 0; n1 = 0; bad = 0; last = -1; first = -1;
    for (int c = 61; c <= 3060; c++) begin
      @(negedge refclk);
      bus.phase_align = 1'b0;
      if (bus.clken[0]) begin
        if (last >= 0 && (c - last < 3 || c - last > 4)) bad++;
        if (first < 0) first = c;
        last = c;
        n0++;
      end
      if (bus.clken[1]) n1++;
    end
    chk("frac_first", 32'(first), 32'd65);
    chk("frac_count", 32'(n0), 32'd999);
    chk("frac_gaps", 32'(bad), 32'd0);
    chk("zero_inc", 32'(n1), 32'd0);

    // Lock loss while lost_clr is held: set must win.
    pll_locked   = 1'b0;
    bus.lost_clr = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge refclk);
      chk($sformatf("loss_e%0d", e),
          32'({bus.ready, bus.lock_lost}),
          (e < 3) ? 32'h2 : 32'h1);
    end
    chk("loss_clken", 32'(bus.clken), 32'h0);
    bus.lost_clr = 1'b0;
    @(negedge refclk);
    chk("loss_sticky", 32'(st()), 32'h4);

    // Clean relock, lock_lost stays set.
    pll_locked = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge refclk);
      chk($sformatf("relock_e%0d", e), 32'(st()),
          (e >= 7) ? 32'hC : 32'h4);
    end

    // Reset mid-RUN clears everything.
    rst = 1'b1;
    @(negedge refclk);
    chk("rst_run", 32'(st()), 32'h0);
    rst = 1'b0;

    for (int e = 1; e <= 7; e++) begin
      @(negedge refclk);
      chk($sformatf("lock2_e%0d", e), 32'(st()),
          (e >= 7) ? 32'h8 : 32'h0);
    end

    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    chk("loss2", 32'(st()), 32'h4);
    bus.lost_clr = 1'b1;
    @(negedge refclk);
    bus.lost_clr = 1'b0;
    chk("lost_clr", 32'(bus.lock_lost), 32'h0);
    @(negedge refclk);
    chk("lost_clr_hold", 32'(st()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
